trap_sequencer: RTL and testbench

- Controller that sequences the machine-mode CSR block around trap entry, trap return (mret) and wfi.
- Sits between the core's commit stage and the CSR block.
- Decides, per committing instruction, whether to take an interrupt or an exception, or to execute mret/wfi.
- Drives the CSR block's handle_trap/exit_trap strobes and the core's stall/flush/redirect controls.

---
 rtl/trap_seq_pkg.sv | 26 ++
 rtl/trap_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the trap sequencer: FSM state encoding,
// machine-mode exception cause codes and the redirect counter width.
package trap_seq_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_TRAP  = 3'd1,
        ST_EXIT  = 3'd2,
        ST_REDIR = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam int unsigned CAUSE_ILLEGAL    = 32'd2;
    localparam int unsigned CAUSE_BREAKPOINT = 32'd3;
    localparam int unsigned CAUSE_ECALL_M    = 32'd11;

    localparam int unsigned REDIR_CNT_W = 32'd3;

    // Counter preload so that REDIR lasts exactly `cycles` clocks (counts down to zero).
    function automatic logic [REDIR_CNT_W-1:0] redir_cnt_init(input int unsigned cycles);
        int unsigned tmp;
        tmp = cycles - 32'd1;
        return tmp[REDIR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry / mret / wfi sequencer between commit stage and machine-mode CSR block.
// Optional WAIT state for wfi is built only when the WFI_EN macro is defined.
module trap_sequencer
    import trap_seq_pkg::*;
#(
    parameter int CAUSE_W         = 31,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instr_pc,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [31:0]        exc_tval,
    input  logic               is_mret,
    input  logic               is_wfi,
    input  logic               wake_pending,
    input  logic               interrupted,
    input  logic [31:0]        trap_pc,
    input  logic [31:0]        ret_pc,
    output logic               commit_en,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               handle_trap,
    output logic               exit_trap,
    output logic               exception,
    output logic [CAUSE_W-1:0] exception_cause,
    output logic [31:0]        trap_value,
    output logic [31:0]        current_pc
);

    state_e                 state_q, state_d;
    logic [REDIR_CNT_W-1:0] cnt_q, cnt_d;
    logic                   flush_q, flush_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [31:0]            redirect_pc_q, redirect_pc_d;
    logic                   handle_trap_q, handle_trap_d;
    logic                   exit_trap_q, exit_trap_d;
    logic                   exception_q, exception_d;
    logic [CAUSE_W-1:0]     exception_cause_q, exception_cause_d;
    logic [31:0]            trap_value_q, trap_value_d;
    logic [31:0]            current_pc_q, current_pc_d;
    logic                   commit_en_s;
    logic                   stall_s;

`ifndef WFI_EN
    logic unused_wfi_s;
    assign unused_wfi_s = is_wfi ^ wake_pending;
`endif

    // Next-state, strobe and payload-latch decode; commit_en/stall follow the commit slot directly.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        flush_d           = 1'b0;
        redirect_valid_d  = 1'b0;
        redirect_pc_d     = redirect_pc_q;
        handle_trap_d     = 1'b0;
        exit_trap_d       = 1'b0;
        exception_d       = exception_q;
        exception_cause_d = exception_cause_q;
        trap_value_d      = trap_value_q;
        current_pc_d      = current_pc_q;
        commit_en_s       = 1'b0;
        stall_s           = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (instr_valid) begin
                    if (interrupted) begin
                        stall_s           = 1'b1;
                        exception_d       = 1'b0;
                        current_pc_d      = instr_pc;
                        trap_value_d      = 32'd0;
                        exception_cause_d = {CAUSE_W{1'b0}};
                        handle_trap_d     = 1'b1;
                        state_d           = ST_TRAP;
                    end else if (exc_valid) begin
                        stall_s           = 1'b1;
                        exception_d       = 1'b1;
                        current_pc_d      = instr_pc;
                        trap_value_d      = exc_tval;
                        exception_cause_d = exc_cause;
                        handle_trap_d     = 1'b1;
                        state_d           = ST_TRAP;
                    end else if (is_mret) begin
                        commit_en_s = 1'b1;
                        stall_s     = 1'b1;
                        exit_trap_d = 1'b1;
                        state_d     = ST_EXIT;
`ifdef WFI_EN
                    end else if (is_wfi) begin
                        commit_en_s = 1'b1;
                        stall_s     = 1'b1;
                        state_d     = ST_WAIT;
`endif
                    end else begin
                        commit_en_s = 1'b1;
                    end
                end else begin
                    commit_en_s = 1'b0;
                end
            end
            ST_TRAP: begin
                stall_s          = 1'b1;
                redirect_pc_d    = trap_pc;
                redirect_valid_d = 1'b1;
                flush_d          = 1'b1;
                cnt_d            = redir_cnt_init(REDIRECT_CYCLES);
                state_d          = ST_REDIR;
            end
            ST_EXIT: begin
                stall_s          = 1'b1;
                redirect_pc_d    = ret_pc;
                redirect_valid_d = 1'b1;
                flush_d          = 1'b1;
                cnt_d            = redir_cnt_init(REDIRECT_CYCLES);
                state_d          = ST_REDIR;
            end
            ST_REDIR: begin
                stall_s = 1'b1;
                if (cnt_q == {REDIR_CNT_W{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - {{(REDIR_CNT_W-1){1'b0}}, 1'b1};
                    flush_d = 1'b1;
                end
            end
`ifdef WFI_EN
            ST_WAIT: begin
                stall_s = 1'b1;
                if (wake_pending) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, counter, strobe and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_RUN;
            cnt_q             <= {REDIR_CNT_W{1'b0}};
            flush_q           <= 1'b0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= 32'd0;
            handle_trap_q     <= 1'b0;
            exit_trap_q       <= 1'b0;
            exception_q       <= 1'b0;
            exception_cause_q <= {CAUSE_W{1'b0}};
            trap_value_q      <= 32'd0;
            current_pc_q      <= 32'd0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            flush_q           <= flush_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            handle_trap_q     <= handle_trap_d;
            exit_trap_q       <= exit_trap_d;
            exception_q       <= exception_d;
            exception_cause_q <= exception_cause_d;
            trap_value_q      <= trap_value_d;
            current_pc_q      <= current_pc_d;
        end
    end

    assign commit_en       = commit_en_s;
    assign stall           = stall_s;
    assign flush           = flush_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign handle_trap     = handle_trap_q;
    assign exit_trap       = exit_trap_q;
    assign exception       = exception_q;
    assign exception_cause = exception_cause_q;
    assign trap_value      = trap_value_q;
    assign current_pc      = current_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer (REDIRECT_CYCLES=3); the wfi
// scenario follows the WFI_EN macro the same way the design does.
module tb_trap_sequencer;
    import trap_seq_pkg::*;

    localparam int CW = 31;
    localparam int RC = 3;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic [31:0]   instr_pc;
    logic          exc_valid;
    logic [CW-1:0] exc_cause;
    logic [31:0]   exc_tval;
    logic          is_mret;
    logic          is_wfi;
    logic          wake_pending;
    logic          interrupted;
    logic [31:0]   trap_pc;
    logic [31:0]   ret_pc;
    logic          commit_en;
    logic          stall;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          handle_trap;
    logic          exit_trap;
    logic          exception;
    logic [CW-1:0] exception_cause;
    logic [31:0]   trap_value;
    logic [31:0]   current_pc;

    int n_assert = 0;
    int n_fail   = 0;

    trap_sequencer #(.CAUSE_W(CW), .REDIRECT_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .is_mret(is_mret), .is_wfi(is_wfi), .wake_pending(wake_pending),
        .interrupted(interrupted), .trap_pc(trap_pc), .ret_pc(ret_pc),
        .commit_en(commit_en), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .handle_trap(handle_trap), .exit_trap(exit_trap), .exception(exception),
        .exception_cause(exception_cause), .trap_value(trap_value),
        .current_pc(current_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        instr_valid  = 1'b0;
        exc_valid    = 1'b0;
        is_mret      = 1'b0;
        is_wfi       = 1'b0;
        interrupted  = 1'b0;
        wake_pending = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        instr_pc  = 32'd0;
        exc_cause = {CW{1'b0}};
        exc_tval  = 32'd0;
        trap_pc   = 32'h0000_0080;
        ret_pc    = 32'h0000_0204;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_commit", 32'(commit_en), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_strobes", {28'd0, handle_trap, exit_trap, flush, redirect_valid}, 32'd0);
        chk("rst_payload", 32'(exception_cause) | trap_value | current_pc | redirect_pc | 32'(exception), 32'd0);

        // Plain commit
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0040;
        #1;
        chk("nop_commit", 32'(commit_en), 32'd1);
        chk("nop_stall", 32'(stall), 32'd0);

        // Synchronous exception: cycle N
        instr_pc  = 32'h0000_0100;
        exc_valid = 1'b1;
        exc_cause = CW'(CAUSE_ILLEGAL);
        exc_tval  = 32'h0000_DEAD;
        #1;
        chk("exc_N_commit", 32'(commit_en), 32'd0);
        chk("exc_N_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("exc_N1_handle", 32'(handle_trap), 32'd1);
        chk("exc_N1_exit", 32'(exit_trap), 32'd0);
        chk("exc_N1_exception", 32'(exception), 32'd1);
        chk("exc_N1_cause", 32'(exception_cause), 32'd2);
        chk("exc_N1_tval", trap_value, 32'h0000_DEAD);
        chk("exc_N1_pc", current_pc, 32'h0000_0100);
        chk("exc_N1_rv", 32'(redirect_valid), 32'd0);
        chk("exc_N1_stall", 32'(stall), 32'd1);
        // Inputs outside RUN must be ignored
        instr_valid = 1'b1;
        exc_valid   = 1'b1;
        interrupted = 1'b1;
        tick();
        #1;
        chk("exc_N2_rv", 32'(redirect_valid), 32'd1);
        chk("exc_N2_rpc", redirect_pc, 32'h0000_0080);
        chk("exc_N2_flush", 32'(flush), 32'd1);
        chk("exc_N2_handle", 32'(handle_trap), 32'd0);
        chk("exc_N2_commit", 32'(commit_en), 32'd0);
        tick();
        #1;
        chk("exc_N3_flush", 32'(flush), 32'd1);
        chk("exc_N3_rv", 32'(redirect_valid), 32'd0);
        tick();
        #1;
        chk("exc_N4_flush", 32'(flush), 32'd1);
        chk("exc_N4_stall", 32'(stall), 32'd1);
        idle_inputs();
        tick();
        #1;
        chk("exc_N5_flush", 32'(flush), 32'd0);
        chk("exc_N5_stall", 32'(stall), 32'd0);
        chk("exc_hold_pc", current_pc, 32'h0000_0100);
        chk("exc_hold_exc", 32'(exception), 32'd1);
        chk("exc_hold_rpc", redirect_pc, 32'h0000_0080);

        // Interrupt wins over a simultaneous exception
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0200;
        interrupted = 1'b1;
        exc_valid   = 1'b1;
        exc_cause   = CW'(CAUSE_ECALL_M);
        exc_tval    = 32'h0000_0055;
        #1;
        chk("irq_N_commit", 32'(commit_en), 32'd0);
        chk("irq_N_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("irq_N1_handle", 32'(handle_trap), 32'd1);
        chk("irq_N1_exception", 32'(exception), 32'd0);
        chk("irq_N1_pc", current_pc, 32'h0000_0200);
        chk("irq_N1_cause", 32'(exception_cause), 32'd0);
        chk("irq_N1_tval", trap_value, 32'd0);
        for (int i = 0; i < RC + 1; i++) tick();
        #1;
        chk("irq_back_run", {30'd0, flush, stall}, 32'd0);

        // mret
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0300;
        is_mret     = 1'b1;
        #1;
        chk("mret_N_commit", 32'(commit_en), 32'd1);
        chk("mret_N_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("mret_N1_exit", 32'(exit_trap), 32'd1);
        chk("mret_N1_handle", 32'(handle_trap), 32'd0);
        tick();
        #1;
        chk("mret_N2_rv", 32'(redirect_valid), 32'd1);
        chk("mret_N2_rpc", redirect_pc, 32'h0000_0204);
        chk("mret_N2_exit", 32'(exit_trap), 32'd0);
        chk("mret_N2_handle", 32'(handle_trap), 32'd0);
        for (int i = 0; i < RC; i++) tick();
        #1;
        chk("mret_back_run", {30'd0, flush, stall}, 32'd0);
        chk("mret_payload_hold", current_pc, 32'h0000_0200);

`ifdef WFI_EN
        // wfi parks in WAIT until wake_pending
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0310;
        is_wfi      = 1'b1;
        #1;
        chk("wfi_N_commit", 32'(commit_en), 32'd1);
        chk("wfi_N_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("wfi_wait_stall", 32'(stall), 32'd1);
            tick();
        end
        wake_pending = 1'b1;
        tick();
        wake_pending = 1'b0;
        #1;
        chk("wfi_woke_stall", 32'(stall), 32'd0);
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0314;
        interrupted = 1'b1;
        #1;
        chk("wfi_irq_commit", 32'(commit_en), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("wfi_irq_handle", 32'(handle_trap), 32'd1);
        chk("wfi_irq_exception", 32'(exception), 32'd0);
        chk("wfi_irq_pc", current_pc, 32'h0000_0314);
        for (int i = 0; i < RC + 1; i++) tick();
        #1;
`else
        // wfi behaves as a plain commit
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0310;
        is_wfi      = 1'b1;
        #1;
        chk("wfi_nop_commit", 32'(commit_en), 32'd1);
        chk("wfi_nop_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("wfi_nop_run", 32'(stall), 32'd0);
`endif

        // Reset while in TRAP aborts the sequence
        instr_valid = 1'b1;
        instr_pc    = 32'h0000_0400;
        exc_valid   = 1'b1;
        exc_cause   = CW'(CAUSE_BREAKPOINT);
        exc_tval    = 32'h0000_0123;
        tick();
        idle_inputs();
        #1;
        chk("rstt_handle", 32'(handle_trap), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstt_strobes", {27'd0, stall, handle_trap, exit_trap, flush, redirect_valid}, 32'd0);
        chk("rstt_payload", 32'(exception_cause) | trap_value | current_pc | redirect_pc | 32'(exception), 32'd0);
        tick();
        #1;
        chk("rstt_no_redirect", {30'd0, flush, redirect_valid}, 32'd0);
        instr_valid = 1'b1;
        #1;
        chk("rstt_run_commit", 32'(commit_en), 32'd1);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
